nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module : nibble_serial_adder_ctrl
// Brief  : W-bit add/subtract performed one nibble per cycle on a shared
//          4-bit ripple-carry adder, LSB nibble first.
// Rev    : 1.0
// ============================================================================

module Ripple_CarryAdder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_fullAdder
      assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = w_carry[4];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0]      c_IDLE = 2'd0;
  localparam logic [1:0]      c_RUN  = 2'd1;
  localparam logic [1:0]      c_DONE = 2'd2;
  localparam logic [IDXW-1:0] c_LAST = IDXW'(NIBBLES - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_nextState;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_bEff;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic            r_cout;
  logic            r_overflow;

  logic [3:0]      w_nibA;
  logic [3:0]      w_nibB;
  logic [3:0]      w_adderSum;
  logic            w_adderCout;
  logic            w_accept;

  assign w_accept = (r_state == c_IDLE) && start;

  // Nibble select for the shared adder, driven from the current index.
  always_comb begin
    w_nibA = 4'd0;
    w_nibB = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_nibA = r_a[4*n +: 4];
        w_nibB = r_bEff[4*n +: 4];
      end
    end
  end

  Ripple_CarryAdder_4bits u_adder (
    .a    (w_nibA),
    .b    (w_nibB),
    .cin  (r_carry),
    .sum  (w_adderSum),
    .cout (w_adderCout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (start) w_nextState = c_RUN;
      c_RUN:   if (r_idx == c_LAST) w_nextState = c_DONE;
      c_DONE:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == c_RUN);
    done     = (r_state == c_DONE);
    sum      = r_sum;
    cout     = r_cout;
    overflow = r_overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_bEff     <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1, so the inversion and the +1 happen here.
      r_a        <= a;
      r_bEff     <= sub ? ~b : b;
      r_carry    <= sub ? 1'b1 : cin;
      r_sum      <= '0;
      r_idx      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (r_state == c_RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (r_idx == IDXW'(n)) r_sum[4*n +: 4] <= w_adderSum;
      end
      r_carry <= w_adderCout;
      r_idx   <= r_idx + 1'b1;
      if (r_idx == c_LAST) begin
        r_cout     <= w_adderCout;
        r_overflow <= (r_a[W-1] == r_bEff[W-1]) && (w_adderSum[3] != r_a[W-1]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// Testbench for nibble_serial_adder_ctrl: directed and random operations
// against a whole-word arithmetic model, with a queue-based scoreboard.

module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } result_t;

  result_t expQ[$];
  result_t lastExp;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  // Whole-word reference: A + Beff + carry, modulo 2^W.
  function automatic result_t refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                       input logic rs, input logic rc);
    logic [W-1:0] beff;
    logic [W:0]   full;
    result_t      r;
    beff   = rs ? ~rb : rb;
    full   = {1'b0, ra} + {1'b0, beff} + (rs ? 1 : rc);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ra[W-1] == beff[W-1]) && (full[W-1] != ra[W-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (busy && done) check("busy_done_exclusive", 32'd1, 32'd0);
    if (!reset && done) begin
      if (expQ.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = expQ.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic ts, input logic tc);
    a = ta; b = tb2; sub = ts; cin = tc; start = 1'b1;
    lastExp = refModel(ta, tb2, ts, tc);
    expQ.push_back(lastExp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int i = 0; i < NIBBLES; i++) begin
      @(negedge clk);
      check("run_busy", 32'({busy, done}), 32'b10);
    end
    @(negedge clk);
    check("done_pulse", 32'({busy, done}), 32'b01);
    @(negedge clk);
    check("idle_hold_sum", 32'({busy, done, sum}), 32'({2'b00, lastExp.sum}));
  endtask

  initial begin
    int doneCnt;
    int doneAt[2];

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({busy, done, cout, overflow, sum}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    runOp(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    runOp(16'h0005, 16'h0007, 1'b1, 1'b0);
    runOp(16'h8000, 16'h0001, 1'b1, 1'b0);
    runOp(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    runOp(16'h0000, 16'h0000, 1'b1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      runOp(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    // start held for 10 edges: two operations, dones 6 cycles apart.
    a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    expQ.push_back(refModel(16'h0001, 16'h0001, 1'b0, 1'b0));
    expQ.push_back(refModel(16'h0001, 16'h0001, 1'b0, 1'b0));
    doneCnt = 0;
    doneAt[0] = 0; doneAt[1] = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done) begin
        if (doneCnt < 2) doneAt[doneCnt] = c;
        doneCnt++;
      end
      if (c >= 10) start = 1'b0;
      if (busy) begin
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end else begin
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0;
      end
    end
    check("held_start_done_count", 32'(doneCnt), 32'd2);
    check("held_start_done_gap", 32'(doneAt[1] - doneAt[0]), 32'd6);

    // Reset in the second RUN cycle aborts the operation.
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("second_run_cycle_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_run_reset", 32'({busy, done, cout, overflow, sum}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    runOp(16'h4321, 16'h1111, 1'b0, 1'b1);

    // Reset wins over start in the same cycle.
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("reset_over_start", 32'(busy), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("still_idle", 32'({busy, done}), 32'd0);
    runOp(16'h8000, 16'h8000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
